core_psum_acc: RTL

CORE_PSUM_ACC -- requirements
Module: core_psum_acc

---
 rtl/core_psum_acc_if.sv | 52 +++++
 rtl/core_psum_acc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_psum_acc_if.sv
// ---------------------------------------------------------------------------
// core_psum_acc_if
// Command, accumulate-stream and drain-stream signals of the partial-sum
// accumulator, grouped so that the block and its user share one bundle.
//
// Parameters:
//   col     - psum lanes per word
//   psum_bw - signed bits per lane
//   addr_bw - word address width
//
// Signals:
//   start, mode[1:0], base_addr, len - command strobe and its arguments
//   in_valid, in_data, in_ready      - ACCUM input stream
//   out_valid, out_data, out_ready   - DRAIN output stream
//   busy, done                       - command status
//
// Modports:
//   slave  - the accumulator side
//   master - the side that issues commands and moves the streams
// ---------------------------------------------------------------------------
interface core_psum_acc_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 6
) ();

  logic                     start;
  logic [1:0]               mode;
  logic [addr_bw-1:0]       base_addr;
  logic [addr_bw:0]         len;
  logic                     in_valid;
  logic [psum_bw*col-1:0]   in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [psum_bw*col-1:0]   out_data;
  logic                     out_ready;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, mode, base_addr, len,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );

  modport master (
    output start, mode, base_addr, len,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/core_psum_acc.sv
// ---------------------------------------------------------------------------
// core_psum_acc
// Partial-sum accumulator: a depth x (col*psum_bw) word memory driven by a
// small command FSM.
//   CLEAR - writes zero to len words starting at base_addr, one per cycle.
//   ACCUM - adds each accepted in_data beat lane-wise (signed, saturating)
//           into the current word, one beat per cycle.
//   DRAIN - streams len words out through a registered valid/ready port.
// Addresses advance modulo depth. Every command ends in a one-cycle done.
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset (memory contents are kept)
//   bus   - core_psum_acc_if.slave (command, ACCUM stream, DRAIN stream,
//           busy/done status)
//
// Build option:
//   CORE_PSUM_ACC_RELU_EN - when defined, DRAIN outputs max(lane, 0) per lane;
//                           when undefined, DRAIN outputs raw signed lanes.
// ---------------------------------------------------------------------------
module core_psum_acc #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64,
  parameter int addr_bw = 6
) (
  input  logic            clk,
  input  logic            reset,
  core_psum_acc_if.slave  bus
);

  localparam int word_bw = psum_bw * col;

  localparam logic [addr_bw-1:0] addr_one = {{(addr_bw-1){1'b0}}, 1'b1};
  localparam logic [addr_bw:0]   cnt_one  = {{addr_bw{1'b0}}, 1'b1};
  localparam logic [addr_bw:0]   cnt_zero = {(addr_bw+1){1'b0}};

  localparam logic [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Lane-wise signed add with saturation. Overflow shows up as the extra
  // sign bit disagreeing with the lane's top bit; the extra bit then tells
  // which rail to clamp to.
  function automatic logic [word_bw-1:0] sat_add_word(
    input logic [word_bw-1:0] a,
    input logic [word_bw-1:0] b
  );
    logic [word_bw-1:0] r;
    logic [psum_bw:0]   s;
    r = '0;
    for (int i = 0; i < col; i++) begin
      s = {a[i*psum_bw + psum_bw - 1], a[i*psum_bw +: psum_bw]}
        + {b[i*psum_bw + psum_bw - 1], b[i*psum_bw +: psum_bw]};
      if (s[psum_bw] != s[psum_bw-1]) begin
        r[i*psum_bw +: psum_bw] = s[psum_bw] ? lane_min : lane_max;
      end else begin
        r[i*psum_bw +: psum_bw] = s[psum_bw-1:0];
      end
    end
    return r;
  endfunction

  // Clamp negative lanes to zero.
  function automatic logic [word_bw-1:0] relu_word(input logic [word_bw-1:0] w);
    logic [word_bw-1:0] r;
    r = w;
    for (int i = 0; i < col; i++) begin
      if (w[i*psum_bw + psum_bw - 1]) begin
        r[i*psum_bw +: psum_bw] = '0;
      end else begin
        r[i*psum_bw +: psum_bw] = w[i*psum_bw +: psum_bw];
      end
    end
    return r;
  endfunction

  // The word as it appears on out_data.
  function automatic logic [word_bw-1:0] drain_view(input logic [word_bw-1:0] w);
`ifdef CORE_PSUM_ACC_RELU_EN
    return relu_word(w);
`else
    return w;
`endif
  endfunction

  state_e               state_q, state_d;
  logic [addr_bw-1:0]   addr_q, addr_d;
  logic [addr_bw:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [word_bw-1:0]   out_data_q, out_data_d;

  logic [word_bw-1:0]   mem_q [depth];
  logic                 mem_we_s;
  logic [word_bw-1:0]   mem_wdata_s;
  logic [addr_bw-1:0]   addr_inc_s;
  logic [word_bw-1:0]   mem_rd_s;
  logic [word_bw-1:0]   mem_rd_nxt_s;

  assign addr_inc_s   = addr_q + addr_one;   // wraps modulo depth
  assign mem_rd_s     = mem_q[addr_q];
  assign mem_rd_nxt_s = mem_q[addr_inc_s];

  // Next-state, address/count and output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          cnt_d  = bus.len;
          if (bus.len == cnt_zero) begin
            state_d = DONE;
          end else begin
            case (bus.mode)
              2'b00:   state_d = CLEAR;
              2'b01:   state_d = ACCUM;
              2'b10:   state_d = DRAIN;
              default: state_d = DONE;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end

      CLEAR: begin
        mem_we_s    = 1'b1;
        mem_wdata_s = '0;
        addr_d      = addr_inc_s;
        cnt_d       = cnt_q - cnt_one;
        if (cnt_q == cnt_one) begin
          state_d = DONE;
        end else begin
          state_d = CLEAR;
        end
      end

      ACCUM: begin
        if (bus.in_valid && in_ready_q) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = sat_add_word(mem_rd_s, bus.in_data);
          addr_d      = addr_inc_s;
          cnt_d       = cnt_q - cnt_one;
          if (cnt_q == cnt_one) begin
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end

      DRAIN: begin
        // addr_q always points at the word currently (or about to be) shown,
        // so a handshake preloads the following word from the second port.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = drain_view(mem_rd_s);
        end else if (bus.out_ready) begin
          if (cnt_q == cnt_one) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            addr_d     = addr_inc_s;
            cnt_d      = cnt_q - cnt_one;
            out_data_d = drain_view(mem_rd_nxt_s);
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    in_ready_d = (state_d == ACCUM);
  end

  // Control and output registers; reset aborts any command at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Psum memory write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= mem_wdata_s;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
